// File: rtl/unshift_seq.sv
// unshift_seq: restores a rotate-right scrambled word by rotating left one bit per clock.
// Define UNSHIFT_ROT2_EN to rotate two bits per clock while at least two steps remain.
module unshift_seq #(
    parameter int W  = 8,
    parameter int SW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in,
    input  logic [SW-1:0] shift,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  q,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;
    state_t        r_state, w_state_nx;
    logic [W-1:0]  r_data, w_data_nx, r_q;
    logic [SW-1:0] r_count, w_count_nx;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nx;
            r_data  <= w_data_nx;
            r_count <= w_count_nx;
            if (w_state_nx == DONE) r_q <= w_data_nx;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_data_nx  = r_data;
        w_count_nx = r_count;
        case (r_state)
            IDLE: if (in_valid) begin
                w_data_nx  = in;
                w_count_nx = shift;
                w_state_nx = (shift == '0) ? DONE : ROT;
            end
            ROT: begin
`ifdef UNSHIFT_ROT2_EN
                if ({1'b0, r_count} >= (SW+1)'(2)) begin
                    w_data_nx  = (r_data << 2) | (r_data >> (W-2));
                    w_count_nx = r_count - SW'(2);
                end else begin
                    w_data_nx  = {r_data[W-2:0], r_data[W-1]};
                    w_count_nx = r_count - SW'(1);
                end
`else
                w_data_nx  = {r_data[W-2:0], r_data[W-1]};
                w_count_nx = r_count - SW'(1);
`endif
                w_state_nx = (w_count_nx == '0) ? DONE : ROT;
            end
            DONE: w_state_nx = out_ready ? IDLE : DONE;
            default: w_state_nx = IDLE;
        endcase
    end
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign q         = r_q;
endmodule

// File: tb/tb_unshift_seq.sv
// tb_unshift_seq: scoreboard bench for unshift_seq; expected words queued at accept, checked at output handshake.
module tb_unshift_seq;
    logic       clk = 0;
    logic       rst = 1;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] d_in = '0;
    logic [2:0] shift = '0;
    logic       out_valid;
    logic       out_ready = 1;
    logic [7:0] q;
    logic       busy;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] sb[$];

    unshift_seq #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in(d_in), .shift(shift), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int lat(input int s);
`ifdef UNSHIFT_ROT2_EN
        return (s + 1) / 2 + 1;
`else
        return s + 1;
`endif
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] x, input int s);
        logic [15:0] t;
        t = {x, x} >> s;
        return t[7:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] d, input logic [2:0] s, input logic [7:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        n_checks++;
        if (!in_ready) $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        else n_pass++;
        in_valid = 1;
        d_in = d;
        shift = s;
        step();
        in_valid = 0;
        d_in = 'x;
        shift = 'x;
        sb.push_back(exp);
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks += 4;
            if (q !== 8'h00) $display("FAIL reset_q: got %h required 00", q); else n_pass++;
            if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
            if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else n_pass++;
            if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
            step();
        end
    endtask

    task automatic test_latency(input logic [7:0] d, input logic [2:0] s, input logic [7:0] exp);
        int n;
        out_ready = 1;
        accept(d, s, exp);
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (n !== lat(s)) $display("FAIL latency_%h_%0d: got %0d cycles required %0d", d, s, n, lat(s));
        else n_pass++;
        n_checks++;
        if (sb.size() == 0) $display("FAIL sb_empty_%h: got empty queue required one entry", d);
        else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (q !== e) $display("FAIL data_%h_%0d: got %h required %h", d, s, q, e);
            else n_pass++;
        end
        step();
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL pulse_%h: out_valid=%b required 0", d, out_valid);
        else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_%h: in_ready=%b required 1", d, in_ready);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] e;
        out_ready = 0;
        accept(8'h5A, 3'd0, 8'h5A);
        e = sb.pop_front();
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            d_in = 8'hFF;
            shift = 3'd3;
            n_checks += 3;
            if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b required 1", out_valid); else n_pass++;
            if (q !== e) $display("FAIL stall_q: got %h required %h", q, e); else n_pass++;
            if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b required 0", in_ready); else n_pass++;
            step();
        end
        in_valid = 0;
        out_ready = 1;
        step();
        n_checks += 2;
        if (out_valid !== 1'b0) $display("FAIL stall_release: out_valid=%b required 0", out_valid); else n_pass++;
        if (busy !== 1'b0) $display("FAIL stall_busy: busy=%b required 0 (FF accepted?)", busy); else n_pass++;
    endtask

    task automatic test_round_trip();
        int n;
        bit done;
        for (int b = 0; b < 256; b++) begin
            for (int s = 0; s < 8; s++) begin
                out_ready = 0;
                accept(rotr(8'(b), s), 3'(s), 8'(b));
                done = 0;
                n = 0;
                while (!done && n < 60) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        logic [7:0] e;
                        e = sb.pop_front();
                        n_checks++;
                        if (q !== e) $display("FAIL round_trip_%h_%0d: got %h required %h", b, s, q, e);
                        else n_pass++;
                        done = 1;
                    end
                    step();
                    n++;
                end
                if (!done) begin
                    n_checks++;
                    $display("FAIL round_trip_timeout_%h_%0d: no output within 60 cycles", b, s);
                    sb.delete();
                end
            end
        end
        out_ready = 1;
    endtask

    task automatic test_mid_reset();
        out_ready = 1;
        accept(8'h01, 3'd7, 8'h01);
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        sb.delete();
        n_checks += 3;
        if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", out_valid); else n_pass++;
        if (q !== 8'h00) $display("FAIL midrst_q: got %h required 00", q); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b required 1", in_ready); else n_pass++;
        test_latency(8'h80, 3'd2, 8'h02);
    endtask

    initial begin
        test_reset();
        test_latency(8'h81, 3'd1, 8'h03);
        test_latency(8'hA5, 3'd3, 8'h2D);
        test_latency(8'h5A, 3'd0, 8'h5A);
        test_latency(8'h01, 3'd7, 8'h80);
        test_stall();
        test_round_trip();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
